// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between fetch and data accesses, data first, with a fetch starvation guard.
module sram_port_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        inst_gnt,
    output logic        data_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic [5:0]  stall
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic        resp, busy, free, inst_win, data_win, rd_gnt, data_stall, inst_stall;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end
    // owner_q: 1 = data read outstanding, 0 = fetch read outstanding
    always_comb begin
        resp        = state_q == WAIT && cnt_q == 3'd1;
        busy        = state_q == WAIT && !resp;
        free        = !rst && (state_q == IDLE || resp);
        inst_win    = free && inst_req && (!data_req || starve_q == 4'(STARVE_LIMIT));
        data_win    = free && data_req && !inst_win;
        rd_gnt      = inst_win || (data_win && data_wen == 4'b0000);
        state_d     = (rd_gnt || busy) ? WAIT : IDLE;
        cnt_d       = rd_gnt ? 3'(RD_LAT) : busy ? cnt_q - 3'd1 : 3'd0;
        owner_d     = rd_gnt ? data_win : owner_q;
        starve_d    = inst_win ? 4'd0 : (inst_req && starve_q < 4'(STARVE_LIMIT)) ? starve_q + 4'd1 : starve_q;
        inst_gnt    = inst_win;
        data_gnt    = data_win;
        sram_en     = inst_win || data_win;
        sram_addr   = data_win ? data_addr : inst_win ? inst_addr : 32'd0;
        sram_wen    = data_win ? data_wen : 4'b0000;
        sram_wdata  = data_win ? data_wdata : 32'd0;
        inst_rvalid = !rst && resp && !owner_q;
        data_rvalid = !rst && resp && owner_q;
        inst_rdata  = inst_rvalid ? sram_rdata : 32'd0;
        data_rdata  = data_rvalid ? sram_rdata : 32'd0;
        data_stall  = !rst && ((data_req && !data_win) || (state_q == WAIT && owner_q));
        inst_stall  = !rst && ((inst_req && !inst_win) || (busy && !owner_q));
        stall       = data_stall ? 6'b011111 : inst_stall ? 6'b000011 : 6'b000000;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks on three arbiter instances with RD_LAT = 1, 2 and 3.
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] sram_rdata = '0;
    logic        sram_en [3];
    logic [3:0]  sram_wen [3];
    logic [31:0] sram_addr [3];
    logic [31:0] sram_wdata [3];
    logic        inst_gnt [3];
    logic        data_gnt [3];
    logic        inst_rvalid [3];
    logic [31:0] inst_rdata [3];
    logic        data_rvalid [3];
    logic [31:0] data_rdata [3];
    logic [5:0]  stall [3];
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_port_arbiter #(.RD_LAT(g + 1), .STARVE_LIMIT(4)) u_dut (
            .clk(clk), .rst(rst),
            .inst_req(inst_req), .inst_addr(inst_addr),
            .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
            .sram_en(sram_en[g]), .sram_wen(sram_wen[g]), .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]),
            .sram_rdata(sram_rdata),
            .inst_gnt(inst_gnt[g]), .data_gnt(data_gnt[g]),
            .inst_rvalid(inst_rvalid[g]), .inst_rdata(inst_rdata[g]),
            .data_rvalid(data_rvalid[g]), .data_rdata(data_rdata[g]),
            .stall(stall[g])
        );
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic smp();
        @(negedge clk);
    endtask
    task automatic reset_all();
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_wen = '0;
        cyc();
        rst = 1'b0;
    endtask
    initial begin
        // reset with requests present: every output must still be 0
        inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_addr = 32'h100;
        cyc(); smp();
        chk("rst_sram_en", 32'(sram_en[0]), 32'd0);
        chk("rst_sram_addr", sram_addr[0], 32'd0);
        chk("rst_inst_gnt", 32'(inst_gnt[0]), 32'd0);
        chk("rst_data_gnt", 32'(data_gnt[0]), 32'd0);
        chk("rst_stall", 32'(stall[0]), 32'd0);
        cyc();
        // RD_LAT=1: lone fetch
        rst = 1'b0; data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h10; sram_rdata = 32'h0;
        smp();
        chk("a1_inst_gnt", 32'(inst_gnt[0]), 32'd1);
        chk("a1_sram_en", 32'(sram_en[0]), 32'd1);
        chk("a1_sram_addr", sram_addr[0], 32'h10);
        chk("a1_stall", 32'(stall[0]), 32'd0);
        cyc();
        inst_req = 1'b0; sram_rdata = 32'h24020005;
        smp();
        chk("a2_inst_rvalid", 32'(inst_rvalid[0]), 32'd1);
        chk("a2_inst_rdata", inst_rdata[0], 32'h24020005);
        chk("a2_stall", 32'(stall[0]), 32'd0);
        chk("a2_data_rvalid", 32'(data_rvalid[0]), 32'd0);
        cyc();
        // simultaneous requests: data wins, fetch granted in the response cycle
        inst_req = 1'b1; inst_addr = 32'h14; data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h100;
        smp();
        chk("a3_data_gnt", 32'(data_gnt[0]), 32'd1);
        chk("a3_inst_gnt", 32'(inst_gnt[0]), 32'd0);
        chk("a3_sram_addr", sram_addr[0], 32'h100);
        chk("a3_stall", 32'(stall[0]), 32'h03);
        cyc();
        data_req = 1'b0; sram_rdata = 32'h11112222;
        smp();
        chk("a4_data_rvalid", 32'(data_rvalid[0]), 32'd1);
        chk("a4_data_rdata", data_rdata[0], 32'h11112222);
        chk("a4_inst_gnt", 32'(inst_gnt[0]), 32'd1);
        chk("a4_sram_addr", sram_addr[0], 32'h14);
        chk("a4_inst_rdata", inst_rdata[0], 32'd0);
        chk("a4_stall", 32'(stall[0]), 32'h1f);
        cyc();
        // store granted in fetch response cycle
        inst_req = 1'b0; data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h200; data_wdata = 32'hDEADBEEF;
        sram_rdata = 32'h33334444;
        smp();
        chk("a5_inst_rvalid", 32'(inst_rvalid[0]), 32'd1);
        chk("a5_inst_rdata", inst_rdata[0], 32'h33334444);
        chk("a5_data_gnt", 32'(data_gnt[0]), 32'd1);
        chk("a5_sram_wen", 32'(sram_wen[0]), 32'h3);
        chk("a5_sram_wdata", sram_wdata[0], 32'hDEADBEEF);
        chk("a5_sram_addr", sram_addr[0], 32'h200);
        chk("a5_stall", 32'(stall[0]), 32'd0);
        cyc();
        data_wen = 4'b0000; data_addr = 32'h300;
        smp();
        chk("a6_data_gnt", 32'(data_gnt[0]), 32'd1);
        chk("a6_data_rvalid", 32'(data_rvalid[0]), 32'd0);
        chk("a6_sram_wen", 32'(sram_wen[0]), 32'd0);
        cyc();
        data_req = 1'b0;
        smp();
        chk("a7_data_rvalid", 32'(data_rvalid[0]), 32'd1);
        cyc();
        // starvation: continuous stores versus a held fetch
        data_req = 1'b1; data_wen = 4'b1111; data_addr = 32'h400; data_wdata = 32'h0BADF00D;
        inst_req = 1'b1; inst_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("s%0d_data_gnt", i), 32'(data_gnt[0]), 32'd1);
            chk($sformatf("s%0d_inst_gnt", i), 32'(inst_gnt[0]), 32'd0);
            chk($sformatf("s%0d_stall", i), 32'(stall[0]), 32'h03);
            cyc();
        end
        smp();
        chk("s4_inst_gnt", 32'(inst_gnt[0]), 32'd1);
        chk("s4_data_gnt", 32'(data_gnt[0]), 32'd0);
        chk("s4_stall", 32'(stall[0]), 32'h1f);
        chk("s4_sram_addr", sram_addr[0], 32'h20);
        chk("s4_sram_wen", 32'(sram_wen[0]), 32'd0);
        chk("s4_sram_wdata", sram_wdata[0], 32'd0);
        cyc();
        inst_addr = 32'h24;
        smp();
        chk("s5_inst_rvalid", 32'(inst_rvalid[0]), 32'd1);
        chk("s5_data_gnt", 32'(data_gnt[0]), 32'd1);
        chk("s5_inst_gnt", 32'(inst_gnt[0]), 32'd0);
        cyc();
        // RD_LAT=3: reset during an outstanding read
        reset_all();
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h500; sram_rdata = 32'h55555555;
        smp();
        chk("b0_data_gnt", 32'(data_gnt[2]), 32'd1);
        cyc();
        data_req = 1'b0; rst = 1'b1;
        smp();
        chk("b1_stall", 32'(stall[2]), 32'd0);
        chk("b1_sram_en", 32'(sram_en[2]), 32'd0);
        chk("b1_data_rvalid", 32'(data_rvalid[2]), 32'd0);
        cyc();
        rst = 1'b0;
        smp();
        chk("b2_stall", 32'(stall[2]), 32'd0);
        chk("b2_data_rvalid", 32'(data_rvalid[2]), 32'd0);
        cyc();
        smp();
        chk("b3_data_rvalid", 32'(data_rvalid[2]), 32'd0);
        chk("b3_data_rdata", data_rdata[2], 32'd0);
        cyc();
        data_req = 1'b1; data_addr = 32'h600; sram_rdata = 32'hCAFEF00D;
        smp();
        chk("b4_data_gnt", 32'(data_gnt[2]), 32'd1);
        cyc();
        data_req = 1'b0;
        smp();
        chk("b5_stall", 32'(stall[2]), 32'h1f);
        chk("b5_sram_en", 32'(sram_en[2]), 32'd0);
        chk("b5_data_rvalid", 32'(data_rvalid[2]), 32'd0);
        cyc();
        smp();
        chk("b6_data_rvalid", 32'(data_rvalid[2]), 32'd0);
        cyc();
        smp();
        chk("b7_data_rvalid", 32'(data_rvalid[2]), 32'd1);
        chk("b7_data_rdata", data_rdata[2], 32'hCAFEF00D);
        cyc();
        smp();
        chk("b8_data_rvalid", 32'(data_rvalid[2]), 32'd0);
        chk("b8_stall", 32'(stall[2]), 32'd0);
        cyc();
        // RD_LAT=2: fetch waiting behind a data read
        reset_all();
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h700; inst_req = 1'b1; inst_addr = 32'h40;
        smp();
        chk("c0_data_gnt", 32'(data_gnt[1]), 32'd1);
        chk("c0_inst_gnt", 32'(inst_gnt[1]), 32'd0);
        chk("c0_stall", 32'(stall[1]), 32'h03);
        cyc();
        data_req = 1'b0;
        smp();
        chk("c1_stall", 32'(stall[1]), 32'h1f);
        chk("c1_inst_gnt", 32'(inst_gnt[1]), 32'd0);
        chk("c1_sram_en", 32'(sram_en[1]), 32'd0);
        cyc();
        smp();
        chk("c2_stall", 32'(stall[1]), 32'h1f);
        chk("c2_inst_gnt", 32'(inst_gnt[1]), 32'd1);
        chk("c2_data_rvalid", 32'(data_rvalid[1]), 32'd1);
        chk("c2_sram_addr", sram_addr[1], 32'h40);
        cyc();
        inst_req = 1'b0;
        smp();
        chk("c3_stall", 32'(stall[1]), 32'h03);
        chk("c3_inst_rvalid", 32'(inst_rvalid[1]), 32'd0);
        cyc();
        smp();
        chk("c4_inst_rvalid", 32'(inst_rvalid[1]), 32'd1);
        chk("c4_stall", 32'(stall[1]), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbiter and sequencer for the single shared SRAM port used by both instruction fetch (IF) and data access (MEM) in the 5-stage pipeline. Grants the port to one requester per access, issues the SRAM control signals, and routes read data back with a valid pulse. Produces the pipeline stall request for the losing or waiting stage. Data has priority over instructions, with a starvation guard for fetch.

## Interface
- RD_LAT, 1: SRAM read latency in cycles; legal range 1..4.
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which fetch gets priority; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_req  in  1  fetch request; held high until granted.
- inst_addr  in  32  fetch word address.
- data_req  in  1  data request; held high until granted.
- data_wen  in  4  byte write enables; 4'b0000 means read.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- sram_en  out  1  SRAM enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid RD_LAT cycles after a read is issued.
- inst_gnt  out  1  fetch accepted this cycle.
- data_gnt  out  1  data access accepted this cycle.
- inst_rvalid  out  1  one-cycle pulse; inst_rdata valid.
- inst_rdata  out  32  fetched instruction.
- data_rvalid  out  1  one-cycle pulse; data_rdata valid.
- data_rdata  out  32  load data.
- stall  out  6  stall request to the stall controller; bit k = Stop for pipeline register k.

## Operation
- FSM states: IDLE (port free) and WAIT (one read outstanding; a countdown counter holds the remaining latency).
- The port is free in IDLE, or in WAIT during the cycle the counter reaches its final cycle (the response cycle). Only one access is outstanding at a time.
- Arbitration happens only when the port is free:
  - Neither request: no grant.
  - One request: that requester is granted.
  - Both requests: data is granted, unless starve_cnt == STARVE_LIMIT, in which case inst is granted.
- Grants are combinational in the same cycle as the request. On a grant, sram_en=1 and sram_addr, sram_wen and sram_wdata are driven from the winner. Fetch grants always drive sram_wen=0 and sram_wdata=0.
- Write grant (data_wen != 0): the write completes in the grant cycle. The FSM goes to or stays in IDLE, and no rvalid is produced.
- Read grant: the FSM enters WAIT with the counter set to RD_LAT and records the owner (inst or data).
  - The counter decrements each cycle.
  - In the response cycle, the owner's rvalid=1 and its rdata = sram_rdata.
  - The response cycle may carry a new grant; otherwise the FSM returns to IDLE.
- rdata outputs are combinational pass-through of sram_rdata, qualified by rvalid. They are 0 when rvalid=0.
- starve_cnt (4 bits):
  - Increments on every cycle with inst_req=1 and inst_gnt=0, saturating at STARVE_LIMIT.
  - Cleared on inst_gnt.
- Stall generation (combinational):
  - data_req=1 and not granted, or data read outstanding (including its response cycle): stall=6'b011111. This holds PC, IF, ID, EX and MEM, and inserts a bubble into WB.
  - Otherwise, inst_req=1 and not granted, or fetch read outstanding before its response cycle: stall=6'b000011. This holds PC and inserts a bubble into ID.
  - Otherwise: stall=6'b000000.
- When both stall conditions hold, the data stall takes precedence.

## Timing
- Reset values: FSM=IDLE, counter=0, owner=inst, starve_cnt=0. All outputs are 0 (sram_en, sram_wen, sram_addr, sram_wdata, gnts, rvalids, rdatas, stall).
- Read latency: grant in cycle t gives rvalid in cycle t+RD_LAT.
- Back-to-back reads: one read every RD_LAT cycles per port.
- Writes: one per cycle when the port is free.
- Reset asserted mid-read: the outstanding read is discarded, no rvalid is ever produced for it, and the next cycle starts in IDLE.
- A request dropped before grant is illegal. Behaviour is unspecified; no protection is required.
- A grant is never issued in a non-response WAIT cycle. sram_en=0 in those cycles.

## Test plan
- RD_LAT=1; inst_req alone, inst_addr=0x00000010, sram_rdata=0x24020005 -> inst_gnt at t, inst_rvalid and inst_rdata=0x24020005 at t+1, stall=6'b000000 at t+1.
- Simultaneous inst_req and data_req (read, addr 0x100) -> data_gnt at t with stall=6'b000011; inst_gnt at t+1 (response cycle); data_rvalid at t+1.
- Store data_wen=4'b0011, addr 0x200, wdata 0xDEADBEEF -> sram_en=1, sram_wen=4'b0011, sram_wdata=0xDEADBEEF for one cycle; no rvalid; the next request is granted the following cycle.
- STARVE_LIMIT=4; data_req held continuously with writes, inst_req held -> inst denied 4 cycles (starve_cnt reaches 4), inst granted on the 5th cycle while data sees stall=6'b011111; starve_cnt returns to 0.
- RD_LAT=3; data read granted, rst asserted at t+1 for one cycle -> no data_rvalid at t+3; all outputs 0 during reset; a fresh read after reset completes in 3 cycles.
- RD_LAT=2; a data read is outstanding while inst_req is pending -> stall=6'b011111 in t+1 and t+2; inst_gnt in t+2; fetch stall=6'b000011 in t+3.
